cpu_fetch_queue: RTL and testbench
==================================

Name: cpu_fetch_queue

Overview:
Next-generation instruction fetch unit for the Klara-RV pipeline. It decouples fetch from decode with a parametrised prefetch queue. It applies static branch prediction so fetch continues past JAL and backward branches instead of stalling. It supports queue flush on redirect and edge-triggered interrupt dispatch. It sits between the instruction bus (or I-cache) and the decode stage, and replaces the strobe-based output with a valid/ready handshake.

Parameters:
RESET_VECTOR, 32'h0, PC loaded on reset.
QUEUE_DEPTH, 4, prefetch queue entries; power of two, >= 2.
PREDICT_JAL, 1, when 1, JAL is followed at fetch; when 0, JAL stops fetch.
PREDICT_BACKWARD, 1, when 1, conditional branches with negative offset are predicted taken; when 0, all are predicted not taken.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_redirect  in  1  execute-stage redirect (mispredict, JALR, MRET, trap return)
i_redirect_pc  in  32  redirect target
i_irq_pending  in  1  interrupt request level
i_irq_pc  in  32  interrupt handler vector
o_irq_dispatched  out  1  one-cycle pulse on dispatch
o_irq_epc  out  32  return PC captured at dispatch
o_bus_request  out  1  bus read request
i_bus_ready  in  1  read data valid / transaction complete
o_bus_address  out  32  read address, word aligned
i_bus_rdata  in  32  read data
o_valid  out  1  queue head valid
i_ready  in  1  decode accepts head
o_instruction  out  32  head instruction
o_pc  out  32  head PC
o_pred_taken  out  1  head was predicted taken
o_pred_pc  out  32  PC fetch continued at after head
o_occupancy  out  $clog2(QUEUE_DEPTH)+1  entries in queue
o_debug_pc  out  32  current fetch PC

Behaviour:
- Reset: fetch pc = RESET_VECTOR; queue empty; state RUN; all outputs 0 except o_debug_pc = RESET_VECTOR. Reset mid-transaction also clears the discard flag; the bus master must tolerate the request dropping.
- Bus: one outstanding read. o_bus_request and o_bus_address are held stable until i_bus_ready. Issue happens only in RUN and when occupancy + outstanding < QUEUE_DEPTH.
- On i_bus_ready (not discarding), push {rdata, pc, pred_taken, next_pc} and compute next_pc in the same cycle:
  - JAL (opcode 1101111) with PREDICT_JAL: pc + J_imm, taken.
  - Branch (1100011) with imm[31]=1 and PREDICT_BACKWARD: pc + B_imm, taken.
  - Other branches: pc + 4, not taken.
  - JALR, MRET, ECALL, WFI (and JAL when PREDICT_JAL=0): push, leave fetch pc = the instruction's PC, enter STOP.
  - Otherwise pc + 4.
- Latency: i_bus_ready at cycle N -> o_valid at N+1 if the queue was empty. Pop occurs on o_valid && i_ready. Push and pop in the same cycle keep occupancy unchanged. A full queue never receives a push, guaranteed by the issue rule.
- States:
  - RUN: fetching.
  - STOP: no new issue; waits for i_redirect or an IRQ edge.
- Redirect (any state): flush queue, pc = i_redirect_pc, state RUN. If a read is outstanding, set discard; its response is dropped and no new issue happens until it completes. A redirect in the same cycle as a bus response wins, and the response is discarded.
- IRQ:
  - The edge {irq_r, i_irq_pending} == 2'b01 sets a sticky irq_req.
  - Dispatch on the first cycle irq_req=1 and i_redirect=0: pulse o_irq_dispatched, flush, apply discard rule, pc = i_irq_pc, state RUN, clear irq_req.
  - o_irq_epc at dispatch: head PC if queue non-empty; else the outstanding request address; else fetch pc.
  - A head popped in the dispatch cycle counts as delivered, so epc is the next entry by the same rule.
- The PC after a taken prediction wraps mod 2^32. o_occupancy counts queue entries only, excluding the outstanding read.

Test Plan:
- Straight-line fetch, always-ready bus and decoder, RESET_VECTOR=0x100 -> o_pc sequence 0x100, 0x104, 0x108…, first o_valid 2 cycles after reset release, occupancy stays ≤ 1.
- Hold i_ready=0 with QUEUE_DEPTH=4 -> exactly 4 entries, o_bus_request deasserts, occupancy=4. Release -> in-order drain, no lost or duplicate PC.
- JAL at 0x200 with offset +0x40 -> entry with o_pred_taken=1, o_pred_pc=0x240, next fetch address 0x240. Backward BEQ at 0x300, offset -8 -> next fetch 0x2F8. Forward branch -> 0x304.
- Redirect to 0x800 while a read is outstanding and 3 entries are queued -> queue empties next cycle, stale response dropped, next address 0x800.
- ECALL at 0x400 -> STOP, no requests. Raise i_irq_pending -> o_irq_dispatched pulse, o_irq_epc=0x400, fetch from i_irq_pc. Hold the level high -> no second dispatch.
- IRQ edge coincident with i_redirect -> redirect applied first, dispatch one cycle later with epc = redirect target. Assert reset mid-burst -> queue empty, pc=RESET_VECTOR.

Source files
------------

// File: rtl/cpu_fetch_queue_if.sv
// cpu_fetch_queue_if: instruction bus and decode handshake between fetch and its neighbours.
interface cpu_fetch_queue_if;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_pc;
  modport master (
    output o_bus_request, o_bus_address, o_valid, o_instruction, o_pc, o_pred_taken, o_pred_pc,
    input  i_bus_ready, i_bus_rdata, i_ready
  );
  modport slave (
    input  o_bus_request, o_bus_address, o_valid, o_instruction, o_pc, o_pred_taken, o_pred_pc,
    output i_bus_ready, i_bus_rdata, i_ready
  );
endinterface

// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: prefetching fetch unit with static branch prediction, redirect flush
// and edge-triggered interrupt dispatch, feeding decode through a valid/ready queue.
module cpu_fetch_queue #(
  parameter logic [31:0] RESET_VECTOR     = 32'h0,
  parameter int          QUEUE_DEPTH      = 4,
  parameter bit          PREDICT_JAL      = 1'b1,
  parameter bit          PREDICT_BACKWARD = 1'b1
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_redirect,
  input  logic [31:0]                  i_redirect_pc,
  input  logic                         i_irq_pending,
  input  logic [31:0]                  i_irq_pc,
  output logic                         o_irq_dispatched,
  output logic [31:0]                  o_irq_epc,
  cpu_fetch_queue_if.master            bus,
  output logic [$clog2(QUEUE_DEPTH):0] o_occupancy,
  output logic [31:0]                  o_debug_pc
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [31:0] WFI   = 32'h1050_0073;
  typedef enum logic {RUN, STOP} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, addr_q, addr_d, epc_q, epc_d;
  logic req_q, req_d, discard_q, discard_d, irq_r_q, irq_req_q, irq_req_d, disp_q;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] ins_m [QUEUE_DEPTH];
  logic [31:0] pc_m [QUEUE_DEPTH];
  logic [31:0] npc_m [QUEUE_DEPTH];
  logic        tk_m [QUEUE_DEPTH];
  logic valid, done, pop, push, hold, dispatch, flush, is_jal, is_br, taken, halt;
  logic [31:0] rdata, j_imm, b_imm, npc, head_next;
  assign rdata  = bus.i_bus_rdata;
  assign is_jal = rdata[6:0] == 7'b1101111;
  assign is_br  = rdata[6:0] == 7'b1100011;
  assign j_imm  = {{12{rdata[31]}}, rdata[19:12], rdata[20], rdata[30:21], 1'b0};
  assign b_imm  = {{20{rdata[31]}}, rdata[7], rdata[30:25], rdata[11:8], 1'b0};
  assign taken  = (is_jal && PREDICT_JAL) || (is_br && rdata[31] && PREDICT_BACKWARD);
  assign halt   = (is_jal && !PREDICT_JAL) || rdata[6:0] == 7'b1100111 ||
                  rdata == ECALL || rdata == MRET || rdata == WFI;
  // A halting instruction parks the fetch pc on itself until redirect or interrupt.
  assign npc    = taken ? addr_q + (is_jal ? j_imm : b_imm) : halt ? addr_q : addr_q + 32'd4;
  assign valid    = cnt_q != '0;
  assign done     = req_q && bus.i_bus_ready;
  assign hold     = req_q && !bus.i_bus_ready;
  assign pop      = valid && bus.i_ready;
  assign dispatch = irq_req_q && !i_redirect;
  assign flush    = i_redirect || dispatch;
  assign push     = done && !discard_q && !flush;
  // A head accepted this cycle is delivered, so the return point is the entry behind it.
  assign head_next = pop ? (cnt_q > CW'(1) ? pc_m[rd_q + AW'(1)] : pc_q) : (valid ? pc_m[rd_q] : pc_q);
  always_comb begin
    pc_d      = i_redirect ? i_redirect_pc : dispatch ? i_irq_pc : push ? npc : pc_q;
    state_d   = flush ? RUN : (push && halt) ? STOP : state_q;
    discard_d = flush ? hold : discard_q && !done;
    cnt_d     = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d      = flush ? '0 : rd_q + AW'(pop);
    wr_d      = flush ? '0 : wr_q + AW'(push);
    req_d     = hold || (state_d == RUN && cnt_d < FULL);
    addr_d    = hold ? addr_q : pc_d;
    irq_req_d = (irq_req_q && !dispatch) || (i_irq_pending && !irq_r_q);
    epc_d     = dispatch ? head_next : epc_q;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      addr_q    <= '0;
      req_q     <= 1'b0;
      discard_q <= 1'b0;
      irq_r_q   <= 1'b0;
      irq_req_q <= 1'b0;
      disp_q    <= 1'b0;
      epc_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      discard_q <= discard_d;
      irq_r_q   <= i_irq_pending;
      irq_req_q <= irq_req_d;
      disp_q    <= dispatch;
      epc_q     <= epc_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
    end
  end
  always_ff @(posedge i_clock) begin
    if (push) begin
      ins_m[wr_q] <= rdata;
      pc_m[wr_q]  <= addr_q;
      npc_m[wr_q] <= npc;
      tk_m[wr_q]  <= taken;
    end
  end
  assign bus.o_bus_request = req_q;
  assign bus.o_bus_address = addr_q;
  assign bus.o_valid       = valid;
  assign bus.o_instruction = valid ? ins_m[rd_q] : '0;
  assign bus.o_pc          = valid ? pc_m[rd_q] : '0;
  assign bus.o_pred_taken  = valid && tk_m[rd_q];
  assign bus.o_pred_pc     = valid ? npc_m[rd_q] : '0;
  assign o_irq_dispatched  = disp_q;
  assign o_irq_epc         = epc_q;
  assign o_occupancy       = cnt_q;
  assign o_debug_pc        = pc_q;
endmodule

// File: tb/tb_cpu_fetch_queue.sv
// tb_cpu_fetch_queue: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level queue model of the fetch unit.
module tb_cpu_fetch_queue;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [31:0] WFI   = 32'h1050_0073;
  typedef struct {logic [31:0] ins, pc, npc; logic tk;} ent_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, redirect, irqp, disp;
  logic [31:0] rpc, irqpc, epc, debug_pc;
  logic [2:0] occ;
  cpu_fetch_queue_if bus_if ();
  cpu_fetch_queue #(.RESET_VECTOR(RV), .QUEUE_DEPTH(DEPTH), .PREDICT_JAL(1'b1), .PREDICT_BACKWARD(1'b1)) dut (
    .i_clock(clk), .i_reset(rst), .i_redirect(redirect), .i_redirect_pc(rpc),
    .i_irq_pending(irqp), .i_irq_pc(irqpc), .o_irq_dispatched(disp), .o_irq_epc(epc),
    .bus(bus_if), .o_occupancy(occ), .o_debug_pc(debug_pc)
  );
  int compared = 0, mismatched = 0, obs_disp = 0;
  ent_t mq[$];
  logic [31:0] m_pc, m_epc, hold_addr;
  logic m_stop, m_stale, m_irq_r, m_irq_req, m_disp, hold_exp;
  bit rand_mode = 0;
  logic [31:0] prog [logic [31:0]];
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  function automatic logic [31:0] enc_j(input int off);
    logic [31:0] i = off;
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_b(input int off);
    logic [31:0] i = off;
    return {i[12], i[10:5], 5'd1, 5'd2, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] rand_ins();
    int k = int'($urandom_range(0, 19));
    int off = (int'($urandom_range(0, 63)) - 32) * 4;
    logic [31:0] r = $urandom;
    if (k < 10) return {r[31:7], 7'b0010011};
    if (k < 13) return enc_j(off);
    if (k < 17) return enc_b(off);
    if (k == 17) return 32'h0000_8067;
    if (k == 18) return ECALL;
    return r[0] ? MRET : WFI;
  endfunction
  function automatic logic [31:0] fetch_data(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return rand_mode ? rand_ins() : NOP;
  endfunction
  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    logic req, done, disp_now;
    logic [31:0] addr, r, jimm, bimm;
    ent_t e;
    req  = bus_if.o_bus_request;
    addr = bus_if.o_bus_address;
    if (rst) begin
      mq.delete();
      m_pc = RV; m_stop = 0; m_stale = 0; m_irq_r = 0; m_irq_req = 0;
      m_disp = 0; m_epc = 0; hold_exp = 0;
      return;
    end
    done = req && bus_if.i_bus_ready;
    if (req && !m_stale) cmp("bus_addr", addr, m_pc);
    if (mq.size() > 0 && bus_if.i_ready) void'(mq.pop_front());
    disp_now = m_irq_req && !redirect;
    if (disp_now) m_epc = mq.size() > 0 ? mq[0].pc : m_pc;
    if (done && !m_stale && !redirect && !disp_now) begin
      r = bus_if.i_bus_rdata;
      jimm = {{11{r[31]}}, r[31], r[19:12], r[20], r[30:21], 1'b0};
      bimm = {{19{r[31]}}, r[31], r[7], r[30:25], r[11:8], 1'b0};
      e.ins = r; e.pc = m_pc; e.tk = 1'b0; e.npc = m_pc + 32'd4;
      if (r[6:0] == 7'b1101111) begin e.tk = 1'b1; e.npc = m_pc + jimm; end
      else if (r[6:0] == 7'b1100011 && r[31]) begin e.tk = 1'b1; e.npc = m_pc + bimm; end
      else if (r[6:0] == 7'b1100111 || r == ECALL || r == MRET || r == WFI) begin e.npc = m_pc; m_stop = 1; end
      cmp("no_overflow", 32'(mq.size() < DEPTH), 32'd1);
      mq.push_back(e);
      m_pc = e.npc;
    end
    if (done) m_stale = 0;
    if (redirect || disp_now) begin
      mq.delete();
      m_pc = redirect ? rpc : irqpc;
      m_stop = 0;
      m_stale = req && !done;
    end
    m_irq_req = (m_irq_req && !disp_now) || (irqp && !m_irq_r);
    m_irq_r = irqp;
    m_disp = disp_now;
    hold_exp = req && !done;
    hold_addr = addr;
  endtask
  task automatic check();
    cmp("occupancy", 32'(occ), 32'(mq.size()));
    cmp("valid", 32'(bus_if.o_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      cmp("head_pc", bus_if.o_pc, mq[0].pc);
      cmp("head_instruction", bus_if.o_instruction, mq[0].ins);
      cmp("head_pred_taken", 32'(bus_if.o_pred_taken), 32'(mq[0].tk));
      cmp("head_pred_pc", bus_if.o_pred_pc, mq[0].npc);
    end
    cmp("irq_dispatched", 32'(disp), 32'(m_disp));
    if (m_disp) cmp("irq_epc", epc, m_epc);
    cmp("debug_pc", debug_pc, m_pc);
    cmp("req_allowed", 32'(bus_if.o_bus_request && (m_stop || mq.size() >= DEPTH)), 32'd0);
    if (hold_exp) begin
      cmp("req_hold", 32'(bus_if.o_bus_request), 32'd1);
      cmp("addr_hold", bus_if.o_bus_address, hold_addr);
    end
    if (disp) obs_disp++;
  endtask
  task automatic step(input logic rdy, input logic brdy);
    bus_if.i_ready = rdy;
    bus_if.i_bus_ready = brdy;
    bus_if.i_bus_rdata = (brdy && bus_if.o_bus_request) ? fetch_data(bus_if.o_bus_address) : 32'h0;
    model_step();
    @(negedge clk);
    check();
    redirect = 1'b0;
  endtask
  task automatic wait_head(input logic [31:0] pc, input string name);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus_if.o_valid && bus_if.o_pc == pc) begin ok = 1; break; end
      step(1'b1, 1'b1);
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL %s: head pc %h, expected %h within 60 cycles", name, bus_if.o_pc, pc);
    end
  endtask
  task automatic do_redirect(input logic [31:0] pc, input logic rdy, input logic brdy);
    redirect = 1'b1;
    rpc = pc;
    step(rdy, brdy);
  endtask
  initial begin
    int d0;
    bit ok;
    rst = 1; redirect = 0; irqp = 0; rpc = 0; irqpc = 0;
    bus_if.i_ready = 0; bus_if.i_bus_ready = 0; bus_if.i_bus_rdata = 0;
    prog[32'h200] = enc_j(32'h40);
    prog[32'h300] = enc_b(-8);
    prog[32'h500] = enc_b(16);
    prog[32'h400] = ECALL;
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0);
    cmp("rst_debug_pc", debug_pc, 32'h100);
    cmp("rst_valid", 32'(bus_if.o_valid), 32'd0);
    cmp("rst_request", 32'(bus_if.o_bus_request), 32'd0);
    cmp("rst_epc", epc, 32'd0);
    // straight-line fetch with everything ready
    rst = 0;
    step(1'b1, 1'b1);
    cmp("first_valid_early", 32'(bus_if.o_valid), 32'd0);
    step(1'b1, 1'b1);
    cmp("first_valid", 32'(bus_if.o_valid), 32'd1);
    cmp("first_pc", bus_if.o_pc, 32'h100);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      cmp("seq_pc", bus_if.o_pc, 32'h100 + 32'(4 * k));
      cmp("seq_occ_le1", 32'(occ <= 1), 32'd1);
    end
    // decoder stalled: queue fills to depth and fetch stops
    repeat (8) step(1'b0, 1'b1);
    cmp("full_occ", 32'(occ), 32'd4);
    cmp("full_request", 32'(bus_if.o_bus_request), 32'd0);
    cmp("full_head", bus_if.o_pc, 32'h120);
    repeat (12) step(1'b1, 1'b1);
    // static prediction
    do_redirect(32'h200, 1'b1, 1'b1);
    wait_head(32'h200, "jal_head");
    cmp("jal_taken", 32'(bus_if.o_pred_taken), 32'd1);
    cmp("jal_pred_pc", bus_if.o_pred_pc, 32'h240);
    wait_head(32'h240, "jal_target");
    do_redirect(32'h300, 1'b1, 1'b1);
    wait_head(32'h300, "bwd_head");
    cmp("bwd_taken", 32'(bus_if.o_pred_taken), 32'd1);
    cmp("bwd_pred_pc", bus_if.o_pred_pc, 32'h2F8);
    wait_head(32'h2F8, "bwd_target");
    do_redirect(32'h500, 1'b1, 1'b1);
    wait_head(32'h500, "fwd_head");
    cmp("fwd_taken", 32'(bus_if.o_pred_taken), 32'd0);
    cmp("fwd_pred_pc", bus_if.o_pred_pc, 32'h504);
    wait_head(32'h504, "fwd_next");
    // redirect with three entries queued and a read in flight
    do_redirect(32'h600, 1'b0, 1'b1);
    for (int i = 0; i < 20 && occ != 3; i++) step(1'b0, 1'b1);
    cmp("pre_redirect_occ", 32'(occ), 32'd3);
    cmp("pre_redirect_req", 32'(bus_if.o_bus_request), 32'd1);
    do_redirect(32'h800, 1'b0, 1'b0);
    cmp("flush_occ", 32'(occ), 32'd0);
    cmp("flush_valid", 32'(bus_if.o_valid), 32'd0);
    step(1'b0, 1'b1);
    cmp("post_stale_req", 32'(bus_if.o_bus_request), 32'd1);
    cmp("post_stale_addr", bus_if.o_bus_address, 32'h800);
    cmp("post_stale_occ", 32'(occ), 32'd0);
    wait_head(32'h800, "redirect_head");
    // ECALL halts fetch; interrupt edge resumes it
    do_redirect(32'h3F8, 1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b1);
    cmp("stop_request", 32'(bus_if.o_bus_request), 32'd0);
    cmp("stop_debug_pc", debug_pc, 32'h400);
    irqpc = 32'h900;
    irqp = 1;
    d0 = obs_disp;
    step(1'b1, 1'b1);
    cmp("irq_not_yet", 32'(disp), 32'd0);
    step(1'b1, 1'b1);
    cmp("irq_pulse", 32'(disp), 32'd1);
    cmp("irq_epc_ecall", epc, 32'h400);
    repeat (6) step(1'b0, 1'b1);
    cmp("irq_single_dispatch", 32'(obs_disp - d0), 32'd1);
    wait_head(32'h900, "irq_head");
    irqp = 0;
    step(1'b1, 1'b1);
    // interrupt edge coincident with redirect
    irqpc = 32'hB00;
    irqp = 1;
    do_redirect(32'hA00, 1'b1, 1'b0);
    cmp("coinc_no_disp", 32'(disp), 32'd0);
    cmp("coinc_pc", debug_pc, 32'hA00);
    step(1'b1, 1'b0);
    cmp("coinc_disp", 32'(disp), 32'd1);
    cmp("coinc_epc", epc, 32'hA00);
    cmp("coinc_new_pc", debug_pc, 32'hB00);
    irqp = 0;
    repeat (4) step(1'b1, 1'b1);
    // randomized traffic, with a reset in the middle of it
    rand_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst = 1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        cmp("midrst_occ", 32'(occ), 32'd0);
        cmp("midrst_pc", debug_pc, RV);
        rst = 0;
      end
      redirect = $urandom_range(0, 99) < 3;
      rpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) < 4) irqp = ~irqp;
      irqpc = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
